// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM encoding,
// frame sync byte and length limits.
package loader_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_SYNC,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam int         LEN_W      = 16;
    localparam int         DEF_ADDR_W = 10;

    // Largest legal word count for a given address width (fills the memory exactly).
    function automatic logic [LEN_W:0] max_len(input int unsigned addr_w);
        return (LEN_W+1)'(1) << addr_w;
    endfunction

    localparam logic [LEN_W:0] MAX_LEN = max_len(DEF_ADDR_W);

endpackage

// File: rtl/program_loader.sv
// Streams a framed, checksummed image into instruction memory and holds the
// cpu in reset until a complete, verified image has been written.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_reset,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam logic [LEN_W:0] LEN_LIMIT = max_len(ADDR_W);

    state_t             state, next;
    logic [LEN_W-1:0]   len;
    logic [ADDR_W-1:0]  idx;
    logic [7:0]         hi;
    logic [7:0]         chk;

    logic [LEN_W-1:0]   new_len;
    logic               len_bad;
    logic               last;
    logic               accept;

    assign new_len = {len[LEN_W-1:8], in_data};
    assign len_bad = (new_len == '0) || ({1'b0, new_len} > LEN_LIMIT);
    assign last    = (LEN_W'(idx) == len - LEN_W'(1));
    assign accept  = in_valid && in_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next;
    end

    always_comb begin
        next      = state;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        cpu_reset = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) next = S_SYNC;
            end
            S_SYNC: begin
                in_ready = 1'b1;
                if (in_valid && in_data == SYNC_BYTE) next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) next = len_bad ? S_ERR : S_DATA_HI;
            end
            S_DATA_HI: begin
                in_ready = 1'b1;
                if (in_valid) next = S_DATA_LO;
            end
            S_DATA_LO: begin
                in_ready = 1'b1;
                if (in_valid) next = S_WRITE;
            end
            S_WRITE: begin
                mem_we = 1'b1;
                next   = last ? S_CHK : S_DATA_HI;
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (in_valid) next = (in_data == chk) ? S_DONE : S_ERR;
            end
            S_DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                cpu_reset = 1'b0;
                if (start) next = S_SYNC;
            end
            S_ERR: begin
                busy  = 1'b0;
                error = 1'b1;
                if (start) next = S_SYNC;
            end
            default: next = S_IDLE;
        endcase
    end

    // Datapath; mem_addr/mem_wdata are staged while the low byte arrives so
    // they are stable for the whole WRITE cycle and hold afterwards.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            len       <= '0;
            idx       <= '0;
            hi        <= '0;
            chk       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                S_SYNC:    if (accept && in_data == SYNC_BYTE) begin
                               chk <= '0;
                               idx <= '0;
                           end
                S_LEN_HI:  if (accept) len[LEN_W-1:8] <= in_data;
                S_LEN_LO:  if (accept) len[7:0] <= in_data;
                S_DATA_HI: if (accept) begin
                               hi  <= in_data;
                               chk <= chk ^ in_data;
                           end
                S_DATA_LO: if (accept) begin
                               chk       <= chk ^ in_data;
                               mem_addr  <= idx;
                               mem_wdata <= DATA_W'({hi, in_data});
                           end
                S_WRITE:   if (!last) idx <= idx + ADDR_W'(1);
                default:   ;
            endcase
        end
    end

endmodule
